multi_way_tlc: RTL

- Parametrised N-way intersection traffic light controller. Successor to the fixed two-way, four-state controller.
- Adds configurable way count, programmable green-min, green-max, yellow and all-red timers, latched per-way demand, round-robin service that skips empty approaches, and rest-in-green when no other approach has demand.
- Drives the lamp outputs of one junction. Fed by per-way traffic sensors, such as the LFSR sensor model in benches.

---
 rtl/multi_way_tlc.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_way_tlc.sv
// -----------------------------------------------------------------------------
// multi_way_tlc
//
// Purpose:
//   N-way junction traffic light controller. One approach owns the junction at
//   a time and goes through GREEN -> YELLOW -> ALLRED. Demand is latched per
//   approach. Service is round-robin and skips approaches with no demand. The
//   current approach stays green while nobody else is waiting.
//
// Optional feature (macro PED_PHASE_EN):
//   Adds a pedestrian phase (phase 11). During this phase all lamps are red
//   and walk=1 for PED_T cycles. A pending pedestrian request takes priority
//   at the end of ALLRED.
//
// Ports:
//   clk         in   rising-edge system clock
//   rst_n       in   asynchronous active-low reset
//   traffic     in   [NUM_WAYS] per-way vehicle sensor (level, clk-synchronous)
//   ped_req     in   pedestrian request            (PED_PHASE_EN only)
//   walk        out  pedestrian walk lamp          (PED_PHASE_EN only)
//   red         out  [NUM_WAYS] red lamp per way
//   yellow      out  [NUM_WAYS] yellow lamp per way
//   green       out  [NUM_WAYS] green lamp per way
//   active_way  out  index of the way owning green/yellow
//   phase       out  00 GREEN, 01 YELLOW, 10 ALLRED, 11 PED
// -----------------------------------------------------------------------------
module multi_way_tlc #(
  parameter int NUM_WAYS  = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
`ifdef PED_PHASE_EN
  , parameter int PED_T   = 5
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WAYS-1:0]         traffic,
`ifdef PED_PHASE_EN
  input  logic                        ped_req,
  output logic                        walk,
`endif
  output logic [NUM_WAYS-1:0]         red,
  output logic [NUM_WAYS-1:0]         yellow,
  output logic [NUM_WAYS-1:0]         green,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic [1:0]                  phase
);

  localparam int AW = $clog2(NUM_WAYS);

  // Phase lengths widened by one bit so that t+1 never wraps before the compare.
  localparam logic [CNT_W:0] G_MIN = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] G_MAX = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] Y_LEN = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] A_LEN = (CNT_W+1)'(ALLRED_T);
`ifdef PED_PHASE_EN
  localparam logic [CNT_W:0] P_LEN = (CNT_W+1)'(PED_T);
`endif
  localparam logic [CNT_W-1:0] T_SAT = '1;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_PED    = 2'b11
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [AW-1:0]       active_q, active_d;
  logic [CNT_W-1:0]    t_q, t_d;
  logic [NUM_WAYS-1:0] req_q, req_d;
  logic [NUM_WAYS-1:0] red_q, red_d;
  logic [NUM_WAYS-1:0] yellow_q, yellow_d;
  logic [NUM_WAYS-1:0] green_q, green_d;
`ifdef PED_PHASE_EN
  logic                ped_q, ped_d;
  logic                walk_q, walk_d;
`endif

  logic [CNT_W:0]      t_inc;
  logic [NUM_WAYS-1:0] active_oh;
  logic                other_req;
  logic [AW-1:0]       next_way;

  assign t_inc     = {1'b0, t_q} + 1'b1;
  assign active_oh = NUM_WAYS'(1) << active_q;

`ifdef PED_PHASE_EN
  assign other_req = (|(req_q & ~active_oh)) | ped_q;
`else
  assign other_req = |(req_q & ~active_oh);
`endif

  // Round-robin search. Scanning from the farthest offset down to the nearest
  // one means the nearest requester after active_q wins. If nobody is
  // requesting, active_q keeps the junction.
  always_comb begin
    int idx;
    idx      = 0;
    next_way = active_q;
    for (int off = NUM_WAYS - 1; off >= 1; off--) begin
      idx = (int'(active_q) + off) % NUM_WAYS;
      if (req_q[idx]) next_way = AW'(idx);
    end
  end

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    t_d      = (t_q == T_SAT) ? t_q : t_q + 1'b1;
    // The way that is currently green does not latch its own demand.
    req_d    = req_q | (traffic & ((phase_q == PH_GREEN) ? ~active_oh : '1));
`ifdef PED_PHASE_EN
    ped_d    = ped_q | (ped_req && (phase_q != PH_PED));
`endif

    case (phase_q)
      PH_GREEN: begin
        if (other_req && (t_inc >= G_MIN) &&
            (!traffic[active_q] || (t_inc >= G_MAX)))
          phase_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (t_inc >= Y_LEN) phase_d = PH_ALLRED;
      end
      PH_ALLRED: begin
        if (t_inc >= A_LEN) begin
`ifdef PED_PHASE_EN
          if (ped_q) begin
            phase_d = PH_PED;
            ped_d   = 1'b0;
          end else begin
`else
          begin
`endif
            phase_d           = PH_GREEN;
            active_d          = next_way;
            req_d[next_way]   = 1'b0;
          end
        end
      end
`ifdef PED_PHASE_EN
      PH_PED: begin
        if (t_inc >= P_LEN) phase_d = PH_ALLRED;
      end
`endif
      default: phase_d = PH_GREEN;
    endcase

    if (phase_d != phase_q) t_d = '0;
  end

  // Lamps are decoded from the next state, so the registered lamps change
  // on the same edge as the phase register.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_lamp
    assign green_d[gi]  = (phase_d == PH_GREEN)  && (active_d == AW'(gi));
    assign yellow_d[gi] = (phase_d == PH_YELLOW) && (active_d == AW'(gi));
    assign red_d[gi]    = !((phase_d == PH_GREEN || phase_d == PH_YELLOW) &&
                            (active_d == AW'(gi)));
  end

`ifdef PED_PHASE_EN
  assign walk_d = (phase_d == PH_PED);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_GREEN;
      active_q <= '0;
      t_q      <= '0;
      req_q    <= '0;
      green_q  <= NUM_WAYS'(1);
      yellow_q <= '0;
      red_q    <= ~NUM_WAYS'(1);
`ifdef PED_PHASE_EN
      ped_q    <= 1'b0;
      walk_q   <= 1'b0;
`endif
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      t_q      <= t_d;
      req_q    <= req_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
`ifdef PED_PHASE_EN
      ped_q    <= ped_d;
      walk_q   <= walk_d;
`endif
    end
  end

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign active_way = active_q;
  assign phase      = phase_q;
`ifdef PED_PHASE_EN
  assign walk       = walk_q;
`endif

endmodule
